dot_product_scheduler: RTL
==========================

DOT_PRODUCT_SCHEDULER -- requirements
Module: dot_product_scheduler

Interface
REQ-001 Parameter NUM_NEURONS, default 10, SHALL set the number of weight rows (neurons) evaluated per job, legal range 1..1023.
REQ-002 Parameter DP_LATENCY, default 2, SHALL set the clock cycles from DotProduct inputs to its value output, legal range 0..7.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 GlobalReset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  job request, sampled only in IDLE.
REQ-006 pixels_in  input  100  ten packed 10-bit unsigned pixels, captured on an accepted start.
REQ-007 wmem_addr  output  10  weight-row address (row index).
REQ-008 wmem_ren  output  1  weight-memory read enable; data SHALL be returned exactly one cycle later.
REQ-009 wmem_rdata  input  190  ten packed 19-bit weights for the row read in the previous cycle.
REQ-010 dp_pixels  output  100  pixel operand to the shared DotProduct.
REQ-011 dp_weights  output  190  weight operand to the shared DotProduct.
REQ-012 dp_value  input  26  signed two's-complement DotProduct result.
REQ-013 busy  output  1  job in progress.
REQ-014 result_valid  output  1  single-cycle strobe qualifying result and result_index.
REQ-015 result  output  26  per-neuron dot product.
REQ-016 result_index  output  10  neuron index of result.
REQ-017 done  output  1  single-cycle end-of-job pulse.
REQ-018 best_value  output  26  largest signed result of the last job, held until next job.
REQ-019 best_index  output  10  index of best_value, held until next job.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on start, ISSUE->DRAIN after row NUM_NEURONS-1 is issued, DRAIN->DONE when the in-flight tracker is empty, DONE->IDLE unconditionally after one cycle.
REQ-021 start sampled high in IDLE at cycle T SHALL latch pixels_in into a pixel register driving dp_pixels; start in any other state SHALL be ignored, as SHALL pixels_in changes after T.
REQ-022 In ISSUE, row k SHALL be issued at cycle T+1+k with wmem_ren=1 and wmem_addr=k; wmem_ren SHALL be 0 in all other states.
REQ-023 dp_weights SHALL be wmem_rdata passed through combinationally, so row k reaches DotProduct at T+2+k.
REQ-024 An in-flight tracker (valid bit plus index per stage, depth 1+DP_LATENCY) SHALL assert result_valid with result=dp_value and result_index=k at cycle T+2+k+DP_LATENCY.
REQ-025 Results SHALL stream one per cycle with no gaps; last result at T+1+NUM_NEURONS+DP_LATENCY, done at T+2+NUM_NEURONS+DP_LATENCY.
REQ-026 busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-027 Argmax: on index-0 result, best_value/best_index SHALL load unconditionally; later results SHALL replace them only if strictly greater (signed 26-bit compare), so ties keep the lowest index.
REQ-028 best_value/best_index SHALL be stable and final when done is 1, and unchanged until the next job's index-0 result.
REQ-029 NUM_NEURONS=1 SHALL give ISSUE for exactly one cycle; DP_LATENCY=0 SHALL give result at T+2+k.
REQ-030 No arithmetic beyond comparison; result SHALL be dp_value unmodified.

Reset
REQ-031 GlobalReset high at a rising edge SHALL force IDLE, clear the tracker and pixel register, and drive busy, done, result_valid, wmem_ren, result, result_index, wmem_addr, best_value, best_index to 0 on the following cycle, overriding start.
REQ-032 GlobalReset during ISSUE or DRAIN SHALL abort the job with no further result_valid or done pulses.

Verification
REQ-033 NUM_NEURONS=10, DP_LATENCY=2, bench DotProduct model, start at T -> wmem_addr 0..9 at T+1..T+10, result_valid at T+4..T+13 with indices 0..9, done only at T+14.
REQ-034 Model results row k = 100*k - 450 -> best_index=9, best_value=450 at done.
REQ-035 All rows return identical value 5 -> best_index=0, best_value=5.
REQ-036 All rows negative, row 3 = -1, others <= -2 -> best_index=3, best_value=-1 (26'h3FFFFFF).
REQ-037 start re-asserted during ISSUE with different pixels_in -> ignored, dp_pixels unchanged, single done pulse.
REQ-038 GlobalReset asserted at T+6 -> all outputs 0 from T+7, no done; new start afterwards completes a normal job.

Source files
------------

// File: rtl/dot_product_scheduler.sv
// Sequences one job: issues weight rows to memory, feeds the shared DotProduct, streams
// per-neuron results and tracks the running argmax.
module dot_product_scheduler #(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned DP_LATENCY  = 2
) (
  input  logic         clk,
  input  logic         GlobalReset,
  input  logic         start,
  input  logic [99:0]  pixels_in,
  output logic [9:0]   wmem_addr,
  output logic         wmem_ren,
  input  logic [189:0] wmem_rdata,
  output logic [99:0]  dp_pixels,
  output logic [189:0] dp_weights,
  input  logic [25:0]  dp_value,
  output logic         busy,
  output logic         result_valid,
  output logic [25:0]  result,
  output logic [9:0]   result_index,
  output logic         done,
  output logic [25:0]  best_value,
  output logic [9:0]   best_index
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  localparam logic [9:0] LastRow = 10'(NUM_NEURONS - 1);

  state_e             state_q;
  logic [9:0]         row_q;
  logic [99:0]        pix_q;
  logic               ren_q;
  logic               busy_q;
  logic               done_q;
  logic [DP_LATENCY:0] vld_q;
  logic [9:0]         idx_q [DP_LATENCY+1];
  logic [25:0]        best_value_q;
  logic [9:0]         best_index_q;
  logic               pending;
  logic               take_best;

  // Entries still behind the output stage; the output stage itself drains this cycle.
  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 0; i < DP_LATENCY; i++) begin
      pending = pending | vld_q[i];
    end
  end

  assign result_valid = vld_q[DP_LATENCY];
  assign result       = result_valid ? dp_value : '0;
  assign result_index = result_valid ? idx_q[DP_LATENCY] : '0;

  // Index 0 always seeds the argmax; strict compare keeps the lowest index on ties.
  assign take_best = result_valid &&
                     ((idx_q[DP_LATENCY] == '0) || ($signed(dp_value) > $signed(best_value_q)));

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q      <= StIdle;
      row_q        <= '0;
      pix_q        <= '0;
      ren_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vld_q        <= '0;
      best_value_q <= '0;
      best_index_q <= '0;
      for (int unsigned i = 0; i <= DP_LATENCY; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= ren_q;
      idx_q[0] <= row_q;
      for (int unsigned i = 1; i <= DP_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end

      if (take_best) begin
        best_value_q <= dp_value;
        best_index_q <= idx_q[DP_LATENCY];
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StIssue;
            pix_q   <= pixels_in;
            row_q   <= '0;
            ren_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StIssue: begin
          if (row_q == LastRow) begin
            state_q <= StDrain;
            row_q   <= '0;
            ren_q   <= 1'b0;
          end else begin
            row_q <= row_q + 10'd1;
          end
        end
        StDrain: begin
          if (!pending) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign wmem_addr  = row_q;
  assign wmem_ren   = ren_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dp_pixels  = pix_q;
  assign dp_weights = wmem_rdata;
  assign best_value = best_value_q;
  assign best_index = best_index_q;

endmodule
